// File: rtl/scene_loader_pkg.sv
// Shared definitions for the scene register block: register map, field widths,
// the packed scene record, receive FSM states, and the field-update helper.
package scene_loader_pkg;

  localparam int NUM_REGS = 9;

  localparam logic [3:0] REG_CMP_EN     = 4'd0;
  localparam logic [3:0] REG_BG_COLOR   = 4'd1;
  localparam logic [3:0] REG_POLY_COLOR = 4'd2;
  localparam logic [3:0] REG_V0_X       = 4'd3;
  localparam logic [3:0] REG_V0_Y       = 4'd4;
  localparam logic [3:0] REG_V1_X       = 4'd5;
  localparam logic [3:0] REG_V1_Y       = 4'd6;
  localparam logic [3:0] REG_V2_X       = 4'd7;
  localparam logic [3:0] REG_V2_Y       = 4'd8;

  localparam int CMP_EN_W     = 2;
  localparam int BG_COLOR_W   = 6;
  localparam int POLY_COLOR_W = 12;
  localparam int VX_W         = 14;
  localparam int VY_W         = 12;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } rx_state_e;

  typedef struct packed {
    logic [CMP_EN_W-1:0]     cmp_en;
    logic [BG_COLOR_W-1:0]   background_color;
    logic [POLY_COLOR_W-1:0] poly_color;
    logic [VX_W-1:0]         v0_x;
    logic [VY_W-1:0]         v0_y;
    logic [VX_W-1:0]         v1_x;
    logic [VY_W-1:0]         v1_y;
    logic [VX_W-1:0]         v2_x;
    logic [VY_W-1:0]         v2_y;
  } scene_regs_t;

  // Each field keeps only the low bits of the 16-bit word; unknown indices leave the record untouched.
  function automatic scene_regs_t scene_write(input scene_regs_t cur, input logic [3:0] idx,
                                              input logic [15:0] w);
    scene_regs_t nxt;
    nxt = cur;
    case (idx)
      REG_CMP_EN:     nxt.cmp_en           = CMP_EN_W'(w);
      REG_BG_COLOR:   nxt.background_color = BG_COLOR_W'(w);
      REG_POLY_COLOR: nxt.poly_color       = POLY_COLOR_W'(w);
      REG_V0_X:       nxt.v0_x             = VX_W'(w);
      REG_V0_Y:       nxt.v0_y             = VY_W'(w);
      REG_V1_X:       nxt.v1_x             = VX_W'(w);
      REG_V1_Y:       nxt.v1_y             = VY_W'(w);
      REG_V2_X:       nxt.v2_x             = VX_W'(w);
      REG_V2_Y:       nxt.v2_y             = VY_W'(w);
      default:        nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/scene_loader_if.sv
// Host SPI lines into the scene register block; the host drives (master),
// the register block listens (slave).
interface scene_loader_if;
  logic spi_sclk;
  logic spi_cs_n;
  logic spi_mosi;

  modport master (output spi_sclk, output spi_cs_n, output spi_mosi);
  modport slave  (input  spi_sclk, input  spi_cs_n, input  spi_mosi);
endinterface

// File: rtl/scene_loader_spi_rx.sv
// SPI mode-0 receiver for the scene block: synchronises the host lines into clk,
// then emits one address byte followed by a stream of 16-bit words per transaction.
module scene_spi_rx
  import scene_loader_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  scene_loader_if.slave spi,
  output logic          addr_valid,
  output logic [3:0]    addr,
  output logic          word_valid,
  output logic [15:0]   word
);

  logic [1:0]  sclk_sync_q, sclk_sync_d;
  logic [1:0]  cs_sync_q, cs_sync_d;
  logic [1:0]  mosi_sync_q, mosi_sync_d;
  logic        sclk_prev_q, sclk_prev_d;
  logic        sclk_s, cs_s, mosi_s, sclk_rise;

  rx_state_e   state_q;
  logic [3:0]  bit_cnt_q;
  logic [14:0] shift_q;
  logic        addr_valid_q, word_valid_q;
  logic [3:0]  addr_q;
  logic [15:0] word_q;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[0], spi.spi_sclk};
    cs_sync_d   = {cs_sync_q[0], spi.spi_cs_n};
    mosi_sync_d = {mosi_sync_q[0], spi.spi_mosi};
    sclk_prev_d = sclk_sync_q[1];
  end

  // Chip select resets to deasserted so reset never looks like a transaction start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= 2'b00;
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b00;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
    end
  end

  assign sclk_s    = sclk_sync_q[1];
  assign cs_s      = cs_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= 4'd0;
      shift_q      <= '0;
      addr_valid_q <= 1'b0;
      addr_q       <= 4'd0;
      word_valid_q <= 1'b0;
      word_q       <= 16'd0;
    end else begin
      addr_valid_q <= 1'b0;
      word_valid_q <= 1'b0;
      if (cs_s) begin
        state_q   <= IDLE;
        bit_cnt_q <= 4'd0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q   <= ADDR;
            bit_cnt_q <= 4'd0;
          end
          ADDR: if (sclk_rise) begin
            shift_q   <= {shift_q[13:0], mosi_s};
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              addr_valid_q <= 1'b1;
              addr_q       <= {shift_q[2:0], mosi_s};
              state_q      <= DATA;
              bit_cnt_q    <= 4'd0;
            end
          end
          DATA: if (sclk_rise) begin
            // Counter wraps 15 -> 0 on its own, so each word boundary restarts the count.
            shift_q   <= {shift_q[13:0], mosi_s};
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd15) begin
              word_valid_q <= 1'b1;
              word_q       <= {shift_q, mosi_s};
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign addr_valid = addr_valid_q;
  assign addr       = addr_q;
  assign word_valid = word_valid_q;
  assign word       = word_q;

endmodule

// File: rtl/scene_loader.sv
// Scene register block: SPI writes into the scene fields. With SCENE_DOUBLE_BUFFER_EN
// defined, writes go to a shadow copy committed on frame_start; otherwise they land directly.
module scene_loader #(
  parameter int NUM_REGS = scene_loader_pkg::NUM_REGS
) (
  input  logic          clk,
  input  logic          rst_n,
  scene_loader_if.slave spi,
  input  logic          frame_start,
  output logic [1:0]    cmp_en,
  output logic [5:0]    background_color,
  output logic [11:0]   poly_color,
  output logic [13:0]   v0_x,
  output logic [13:0]   v1_x,
  output logic [13:0]   v2_x,
  output logic [11:0]   v0_y,
  output logic [11:0]   v1_y,
  output logic [11:0]   v2_y,
  output logic          dirty
);
  import scene_loader_pkg::*;

  logic        addr_valid, word_valid;
  logic [3:0]  addr;
  logic [15:0] word;
  logic [3:0]  idx_q, idx_d;
  logic        wr_hit;
  scene_regs_t active_q, active_d;

  scene_spi_rx u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi        (spi),
    .addr_valid (addr_valid),
    .addr       (addr),
    .word_valid (word_valid),
    .word       (word)
  );

  // Index advances on every completed word, including dropped ones, and wraps at 16.
  always_comb begin
    idx_d = idx_q;
    if (addr_valid) begin
      idx_d = addr;
    end else if (word_valid) begin
      idx_d = idx_q + 4'd1;
    end
  end

  assign wr_hit = word_valid && (int'(idx_q) < NUM_REGS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= 4'd0;
    end else begin
      idx_q <= idx_d;
    end
  end

`ifdef SCENE_DOUBLE_BUFFER_EN
  scene_regs_t shadow_q, shadow_d;
  logic        dirty_q, dirty_d;

  // Commit copies the registered shadow, so a write in the same cycle stays pending.
  always_comb begin
    shadow_d = wr_hit ? scene_write(shadow_q, idx_q, word) : shadow_q;
    active_d = frame_start ? shadow_q : active_q;
    dirty_d  = dirty_q;
    if (wr_hit) begin
      dirty_d = 1'b1;
    end else if (frame_start) begin
      dirty_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      dirty_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      dirty_q  <= dirty_d;
    end
  end

  assign dirty = dirty_q;
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start;

  always_comb begin
    active_d = wr_hit ? scene_write(active_q, idx_q, word) : active_q;
  end

  assign dirty = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= '0;
    end else begin
      active_q <= active_d;
    end
  end

  assign cmp_en           = active_q.cmp_en;
  assign background_color = active_q.background_color;
  assign poly_color       = active_q.poly_color;
  assign v0_x             = active_q.v0_x;
  assign v0_y             = active_q.v0_y;
  assign v1_x             = active_q.v1_x;
  assign v1_y             = active_q.v1_y;
  assign v2_x             = active_q.v2_x;
  assign v2_y             = active_q.v2_y;

endmodule

// File: tb/tb_scene_loader.sv
// Self-checking bench for scene_loader: table-driven single writes, hand-written corner
// sequences and random bursts checked against an array-based model of the register map.
module tb_scene_loader;
  import scene_loader_pkg::*;

  localparam int HALF = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic [1:0]  cmp_en;
  logic [5:0]  background_color;
  logic [11:0] poly_color;
  logic [13:0] v0_x, v1_x, v2_x;
  logic [11:0] v0_y, v1_y, v2_y;
  logic        dirty;

  scene_loader_if spi_if();

  scene_loader #(.NUM_REGS(9)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .spi              (spi_if),
    .frame_start      (frame_start),
    .cmp_en           (cmp_en),
    .background_color (background_color),
    .poly_color       (poly_color),
    .v0_x             (v0_x),
    .v1_x             (v1_x),
    .v2_x             (v2_x),
    .v0_y             (v0_y),
    .v1_y             (v1_y),
    .v2_y             (v2_y),
    .dirty            (dirty)
  );

  always #5 clk = ~clk;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int unsigned shadow_m [9];
  int unsigned active_m [9];
  bit          dirty_m;
  int          widths [9] = '{2, 6, 12, 14, 12, 14, 12, 14, 12};
  logic [15:0] wq [$];

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    int          out_idx;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [15:0] dut_out(input int i);
    case (i)
      0: return 16'(cmp_en);
      1: return 16'(background_color);
      2: return 16'(poly_color);
      3: return 16'(v0_x);
      4: return 16'(v0_y);
      5: return 16'(v1_x);
      6: return 16'(v1_y);
      7: return 16'(v2_x);
      default: return 16'(v2_y);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic model_write(input int idx, input int unsigned val);
    int unsigned v;
    if (idx < 9) begin
      v = val % (32'd1 << widths[idx]);
`ifdef SCENE_DOUBLE_BUFFER_EN
      shadow_m[idx] = v;
      dirty_m = 1'b1;
`else
      active_m[idx] = v;
`endif
    end
  endtask

  task automatic model_xfer(input logic [7:0] a);
    int idx;
    idx = int'(a) % 16;
    foreach (wq[k]) begin
      model_write(idx, int'(wq[k]));
      idx = (idx + 1) % 16;
    end
  endtask

  task automatic model_commit();
`ifdef SCENE_DOUBLE_BUFFER_EN
    for (int i = 0; i < 9; i++) active_m[i] = shadow_m[i];
    dirty_m = 1'b0;
`endif
  endtask

  task automatic model_reset();
    for (int i = 0; i < 9; i++) begin
      shadow_m[i] = 0;
      active_m[i] = 0;
    end
    dirty_m = 1'b0;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      spi_if.spi_mosi = v[i];
      wait_clk(HALF);
      spi_if.spi_sclk = 1'b1;
      wait_clk(HALF);
      spi_if.spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_begin();
    spi_if.spi_cs_n = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic spi_end();
    wait_clk(HALF);
    spi_if.spi_cs_n = 1'b1;
    wait_clk(2 * HALF);
  endtask

  task automatic spi_xfer(input logic [7:0] a);
    spi_begin();
    send_bits(16'(a), 8);
    foreach (wq[k]) send_bits(wq[k], 16);
    spi_end();
    model_xfer(a);
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    wait_clk(1);
    frame_start = 1'b0;
    model_commit();
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 9; i++)
      chk($sformatf("%s_reg%0d", tag, i), 32'(dut_out(i)), active_m[i]);
    chk($sformatf("%s_dirty", tag), 32'(dirty), 32'(dirty_m));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h00, 16'hFFFF, 0, 16'h0003};
    vecs[1] = '{8'h01, 16'hFFC5, 1, 16'h0005};
    vecs[2] = '{8'h02, 16'hA5A5, 2, 16'h05A5};
    vecs[3] = '{8'h03, 16'hC001, 3, 16'h0001};
    vecs[4] = '{8'h04, 16'h7FFF, 4, 16'h0FFF};
    vecs[5] = '{8'h05, 16'h2AAA, 5, 16'h2AAA};
    vecs[6] = '{8'h06, 16'hF123, 6, 16'h0123};
    vecs[7] = '{8'h07, 16'h4000, 7, 16'h0000};
    vecs[8] = '{8'hF8, 16'h0ABC, 8, 16'h0ABC};

    rst_n = 1'b0;
    frame_start = 1'b0;
    spi_if.spi_sclk = 1'b0;
    spi_if.spi_cs_n = 1'b1;
    spi_if.spi_mosi = 1'b0;
    model_reset();
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(4);
    check_all("reset");

    // Write and commit
    wq = '{16'h0FC3};
    spi_xfer(8'h02);
    check_all("wr_pending");
    frame_pulse();
    check_all("wr_commit");
    chk("wr_poly_color", 32'(poly_color), 32'h0FC3);
    chk("wr_dirty_clear", 32'(dirty), 32'h0);

    // Burst with truncation
    wq = '{16'h3FFF, 16'hFFFF, 16'h1234};
    spi_xfer(8'h03);
    frame_pulse();
    check_all("burst");
    chk("burst_v0_x", 32'(v0_x), 32'h3FFF);
    chk("burst_v0_y", 32'(v0_y), 32'h0FFF);
    chk("burst_v1_x", 32'(v1_x), 32'h1234);

    // Abort after 10 data bits
    spi_begin();
    send_bits(16'h0001, 8);
    send_bits(16'hFFFF, 10);
    spi_end();
    check_all("abort_pre");
    frame_pulse();
    check_all("abort_post");
    wq = '{16'h0015};
    spi_xfer(8'h01);
    frame_pulse();
    chk("abort_retry_bg", 32'(background_color), 32'h15);

    // Out-of-range index
    wq = '{16'h0ABC, 16'h0777};
    spi_xfer(8'h08);
    frame_pulse();
    check_all("oor");
    chk("oor_v2_y", 32'(v2_y), 32'h0ABC);

    // Index wrap: 15 is dropped, next word lands in index 0
    wq = '{16'h1111, 16'h0002};
    spi_xfer(8'h0F);
    frame_pulse();
    check_all("wrap");
    chk("wrap_cmp_en", 32'(cmp_en), 32'h2);

    // Table-driven single-word writes
    for (int t = 0; t < 9; t++) begin
      wq = '{vecs[t].data};
      spi_xfer(vecs[t].addr);
      frame_pulse();
      chk($sformatf("vec%0d", t), 32'(dut_out(vecs[t].out_idx)), 32'(vecs[t].exp));
    end
    check_all("vec_all");

    // Random bursts against the model
    for (int r = 0; r < 25; r++) begin
      int n;
      logic [7:0] a;
      a = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 3);
      wq.delete();
      for (int k = 0; k < n; k++) wq.push_back(16'($urandom));
      spi_xfer(a);
      if ($urandom_range(0, 1) == 1) frame_pulse();
      check_all($sformatf("rand%0d", r));
    end

    // Start from cmp_en = 0 in both shadow and active copies
    wq = '{16'h0000};
    spi_xfer(8'h00);
    frame_pulse();

`ifdef SCENE_DOUBLE_BUFFER_EN
    begin : coincident
      bit found;
      found = 1'b0;
      spi_begin();
      send_bits(16'h0000, 8);
      send_bits(16'h0003, 15);
      spi_if.spi_mosi = 1'b1;
      wait_clk(HALF);
      spi_if.spi_sclk = 1'b1;
      frame_start = 1'b1;
      for (int k = 0; k < 20; k++) begin
        wait_clk(1);
        if (dirty === 1'b1) begin
          found = 1'b1;
          break;
        end
      end
      frame_start = 1'b0;
      chk("coincident_write_seen", 32'(found), 32'h1);
      chk("coincident_cmp_en", 32'(cmp_en), 32'h0);
      chk("coincident_dirty", 32'(dirty), 32'h1);
      wait_clk(HALF);
      spi_if.spi_sclk = 1'b0;
      spi_end();
      model_write(0, 3);
      check_all("coincident_hold");
      frame_pulse();
      chk("coincident_next_cmp_en", 32'(cmp_en), 32'h3);
    end
`else
    begin : direct
      int lat;
      bit dirty_seen;
      lat = -1;
      dirty_seen = 1'b0;
      spi_begin();
      send_bits(16'h0000, 8);
      send_bits(16'h0003, 15);
      spi_if.spi_mosi = 1'b1;
      wait_clk(HALF);
      chk("direct_pre_cmp_en", 32'(cmp_en), 32'h0);
      spi_if.spi_sclk = 1'b1;
      for (int k = 1; k <= 10; k++) begin
        wait_clk(1);
        if (dirty !== 1'b0) dirty_seen = 1'b1;
        if (cmp_en === 2'b11) begin
          lat = k;
          break;
        end
      end
      chk("direct_latency", 32'(lat), 32'd4);
      chk("direct_dirty_low", 32'(dirty_seen), 32'h0);
      wait_clk(HALF);
      spi_if.spi_sclk = 1'b0;
      spi_end();
      model_write(0, 3);
      check_all("direct_after");
    end
`endif

    // Reset mid-word with non-zero active values
    wq = '{16'h002A};
    spi_xfer(8'h01);
    frame_pulse();
    spi_begin();
    send_bits(16'h0003, 8);
    send_bits(16'h5555, 7);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    chk("async_reset_fsm_idle", 32'(dut.u_rx.state_q), 32'(IDLE));
    spi_if.spi_cs_n = 1'b1;
    spi_if.spi_sclk = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(4);
    wq = '{16'h0BEE, 16'h0123};
    spi_xfer(8'h05);
    frame_pulse();
    check_all("post_reset");
    chk("post_reset_v1_x", 32'(v1_x), 32'h0BEE);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
